// File: rtl/jk_drv_pkg.sv
// Shared definitions for the JK bank driver: FSM state encoding, command codes
// and the retry counter width.
package jk_drv_pkg;

   localparam int RETRY_W = 4;

   localparam logic CMD_LOAD  = 1'b0;
   localparam logic CMD_COUNT = 1'b1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      CHECK = 3'd2,
      DONE  = 3'd3,
      FAIL  = 3'd4
   } state_t;

endpackage

// File: rtl/jk_excite.sv
// Combinational J/K excitation for a WIDTH-bit JK bank (current q -> wanted n).
// Build option JK_TOGGLE_EN: every differing bit is driven J=K=1 (toggle).
module jk_excite #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] n,
   input  logic             active,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
`ifdef JK_TOGGLE_EN
         assign j[gi] = active & (q[gi] ^ n[gi]);
         assign k[gi] = active & (q[gi] ^ n[gi]);
`else
         // Only the input that forces the change is raised; the other stays 0.
         assign j[gi] = active & ~q[gi] &  n[gi];
         assign k[gi] = active &  q[gi] & ~n[gi];
`endif
      end
   endgenerate

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a JK flip-flop bank to a LOAD target or through COUNT increments,
// verifying each step from the fed-back Q and retrying bounded times (see JK_TOGGLE_EN in jk_excite).
module jk_bank_driver
   import jk_drv_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_RETRY = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cmd,
   input  logic [WIDTH-1:0] target,
   input  logic [WIDTH-1:0] q_fb,
   output logic             en,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);
   localparam logic [WIDTH-1:0]   ONE         = WIDTH'(1);

   state_t             state_reg;
   logic [WIDTH-1:0]   steps_reg;
   logic [WIDTH-1:0]   expected_reg;
   logic [RETRY_W-1:0] retry_reg;
   logic               match;

   assign match = (q_fb == expected_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         steps_reg    <= '0;
         expected_reg <= '0;
         retry_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  retry_reg <= '0;
                  if (cmd == CMD_LOAD) begin
                     expected_reg <= target;
                     steps_reg    <= ONE;
                     state_reg    <= DRIVE;
                  end else begin
                     expected_reg <= q_fb + ONE;
                     steps_reg    <= target;
                     state_reg    <= (target == '0) ? DONE : DRIVE;
                  end
               end
            end
            DRIVE: state_reg <= CHECK;
            CHECK: begin
               if (match) begin
                  if (steps_reg == ONE) begin
                     state_reg <= DONE;
                  end else begin
                     // Step verified: advance to the next count value with a fresh retry budget.
                     steps_reg    <= steps_reg - ONE;
                     expected_reg <= expected_reg + ONE;
                     retry_reg    <= '0;
                     state_reg    <= DRIVE;
                  end
               end else if (retry_reg < MAX_RETRY_C) begin
                  retry_reg <= retry_reg + 1'b1;
                  state_reg <= DRIVE;
               end else begin
                  state_reg <= FAIL;
               end
            end
            DONE:    state_reg <= IDLE;
            FAIL:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign en   = (state_reg == DRIVE);
   assign busy = (state_reg != IDLE);
   assign done = (state_reg == DONE);
   assign err  = (state_reg == FAIL);

   jk_excite #(
      .WIDTH (WIDTH)
   ) u_excite (
      .q      (q_fb),
      .n      (expected_reg),
      .active (en),
      .j      (j),
      .k      (k)
   );

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench for jk_bank_driver: a model JK bank (with stuck-at mask),
// a table of directed commands, hand-written corner sequences and random commands.
module tb_jk_bank_driver;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         cmd;
   logic [W-1:0] target;
   logic [W-1:0] q_fb;
   logic         en;
   logic [W-1:0] j;
   logic [W-1:0] k;
   logic         busy;
   logic         done;
   logic         err;

   logic [W-1:0] bank_q;
   logic [W-1:0] stuck;
   logic         preset_req;
   logic [W-1:0] preset_val;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   jk_bank_driver #(.WIDTH(W), .MAX_RETRY(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .cmd    (cmd),
      .target (target),
      .q_fb   (q_fb),
      .en     (en),
      .j      (j),
      .k      (k),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   // Model bank: JK flops with enable, D = J&~Q | ~K&Q; stuck bits read as 0.
   assign q_fb = bank_q & ~stuck;
   always @(posedge clk) begin
      if (preset_req)
         bank_q <= preset_val;
      else if (en)
         bank_q <= (j & ~q_fb) | (~k & q_fb);
   end

   typedef struct {
      logic [W-1:0] q0;
      logic         cmd;
      logic [W-1:0] target;
      logic [W-1:0] stuck;
      logic [W-1:0] exp_q;
      int           exp_done;
      int           exp_err;
      int           exp_en;
   } vec_t;

   vec_t vecs [6];

   // Results of the last run
   int           done_cyc, err_cyc, idle_cyc, en_cnt, done_cnt, err_cnt;
   logic [W-1:0] j_rec [32];
   logic [W-1:0] k_rec [32];
   logic [W-1:0] q_rec [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] exp_n(input logic c, input logic [W-1:0] q0,
                                           input logic [W-1:0] t, input int i);
      return (c == 1'b0) ? t : W'(q0 + i + 1);
   endfunction

   function automatic logic [2*W-1:0] exp_jk(input logic [W-1:0] q, input logic [W-1:0] n);
`ifdef JK_TOGGLE_EN
      return {q ^ n, q ^ n};
`else
      return {~q & n, q & ~n};
`endif
   endfunction

   task automatic run(input logic [W-1:0] q0, input logic c, input logic [W-1:0] t,
                      input logic [W-1:0] stk, input int inj_start, input int inj_reset);
      int cyc;
      @(posedge clk); #1;
      preset_req = 1'b1; preset_val = q0; stuck = stk;
      @(posedge clk); #1;
      preset_req = 1'b0;
      start = 1'b1; cmd = c; target = t;
      cyc = 0;
      done_cyc = 0; err_cyc = 0; idle_cyc = 0; en_cnt = 0; done_cnt = 0; err_cnt = 0;
      while (1) begin
         @(posedge clk); #1;
         cyc++;
         start  = (cyc == inj_start);
         if (cyc == inj_start) begin cmd = 1'b0; target = '0; end
         reset  = (cyc == inj_reset);
         if (en) begin
            if (en_cnt < 32) begin
               j_rec[en_cnt] = j; k_rec[en_cnt] = k; q_rec[en_cnt] = q_fb;
            end
            en_cnt++;
         end else begin
            chk("jk_idle", {j, k}, '0);
         end
         if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = cyc; end
         if (err)  begin err_cnt++;  if (err_cyc == 0)  err_cyc = cyc;  end
         if (!busy) begin idle_cyc = cyc; break; end
         if (cyc >= 60) begin chk("timeout_busy", busy, 0); break; end
      end
      start = 1'b0; reset = 1'b0;
      // Short watch window: nothing may happen once back in IDLE.
      repeat (3) begin
         @(posedge clk); #1;
         if (en)   en_cnt++;
         if (done) done_cnt++;
         if (err)  err_cnt++;
      end
      $display("[TB] cmd=%0d q0=%h target=%h stuck=%h -> done@%0d err@%0d idle@%0d en=%0d q=%h",
               c, q0, t, stk, done_cyc, err_cyc, idle_cyc, en_cnt, q_fb);
   endtask

   task automatic check_run(input string name, input logic [W-1:0] q0, input logic c,
                            input logic [W-1:0] t, input logic [W-1:0] eq,
                            input int ed, input int ee, input int een);
      logic [2*W-1:0] ejk;
      chk({name, "_done_cyc"}, done_cyc, ed);
      chk({name, "_err_cyc"}, err_cyc, ee);
      chk({name, "_idle_cyc"}, idle_cyc, ((ed != 0) ? ed : ee) + 1);
      chk({name, "_done_cnt"}, done_cnt, (ed != 0) ? 1 : 0);
      chk({name, "_err_cnt"}, err_cnt, (ee != 0) ? 1 : 0);
      chk({name, "_en_cnt"}, en_cnt, een);
      chk({name, "_final_q"}, q_fb, eq);
      for (int i = 0; i < en_cnt && i < 32; i++) begin
         ejk = exp_jk(q_rec[i], exp_n(c, q0, t, i));
         chk({name, "_jk"}, {j_rec[i], k_rec[i]}, ejk);
      end
   endtask

   initial begin
      logic [W-1:0] rq0, rt;
      logic         rc;
      int           ed, een;
      logic [W-1:0] eq;

      vecs[0] = '{4'h6, 1'b0, 4'hA, 4'h0, 4'hA, 3,  0, 1};
      vecs[1] = '{4'hE, 1'b1, 4'h3, 4'h0, 4'h1, 7,  0, 3};
      vecs[2] = '{4'h5, 1'b1, 4'h0, 4'h0, 4'h5, 1,  0, 0};
      vecs[3] = '{4'h9, 1'b0, 4'h9, 4'h0, 4'h9, 3,  0, 1};
      vecs[4] = '{4'h0, 1'b1, 4'hF, 4'h0, 4'hF, 31, 0, 15};
      vecs[5] = '{4'h0, 1'b0, 4'h1, 4'h1, 4'h0, 0,  9, 4};

      // Reset held two cycles with a start request that must be ignored
      reset = 1'b1; start = 1'b1; cmd = 1'b1; target = 4'hF;
      preset_req = 1'b1; preset_val = '0; stuck = '0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("reset_outputs", {en, j, k, busy, done, err}, '0);
      end
      reset = 1'b0; start = 1'b0; preset_req = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_idle", {en, busy, done, err}, '0);

      for (int vi = 0; vi < 6; vi++) begin
         run(vecs[vi].q0, vecs[vi].cmd, vecs[vi].target, vecs[vi].stuck, -1, -1);
         check_run($sformatf("vec%0d", vi), vecs[vi].q0, vecs[vi].cmd, vecs[vi].target,
                   vecs[vi].exp_q, vecs[vi].exp_done, vecs[vi].exp_err, vecs[vi].exp_en);
`ifdef JK_TOGGLE_EN
         if (vi == 0) chk("load_first_jk", {j_rec[0], k_rec[0]}, 8'hCC);
         if (vi == 1) chk("wrap_jk", {j_rec[1], k_rec[1]}, 8'hFF);
`else
         if (vi == 0) chk("load_first_jk", {j_rec[0], k_rec[0]}, 8'h84);
         if (vi == 1) chk("wrap_jk", {j_rec[1], k_rec[1]}, 8'h0F);
`endif
         if (vi == 1) chk("wrap_q_seq", {q_rec[1], q_rec[2]}, 8'hF0);
      end

      // Start pulse while busy in a COUNT is ignored
      run(4'h0, 1'b1, 4'h3, 4'h0, 2, -1);
      check_run("busy_start", 4'h0, 1'b1, 4'h3, 4'h3, 7, 0, 3);

      // Reset during cycle 3 of COUNT 5 aborts silently
      run(4'h2, 1'b1, 4'h5, 4'h0, -1, 3);
      chk("abort_idle_cyc", idle_cyc, 4);
      chk("abort_done_err", done_cnt + err_cnt, 0);
      chk("abort_en_cnt", en_cnt, 2);
      chk("abort_q", q_fb, 4'h4);
      run(4'h3, 1'b0, 4'h7, 4'h0, -1, -1);
      check_run("after_abort", 4'h3, 1'b0, 4'h7, 4'h7, 3, 0, 1);

      // Random commands on a clean bank against the arithmetic model
      for (int r = 0; r < 20; r++) begin
         rq0 = W'($urandom_range(0, 15));
         rt  = W'($urandom_range(0, 15));
         rc  = 1'($urandom_range(0, 1));
         if (rc == 1'b0) begin
            eq = rt; ed = 3; een = 1;
         end else begin
            eq  = W'(rq0 + rt);
            ed  = (rt == 0) ? 1 : 2 * int'(rt) + 1;
            een = int'(rt);
         end
         run(rq0, rc, rt, 4'h0, -1, -1);
         check_run($sformatf("rand%0d", r), rq0, rc, rt, eq, ed, 0, een);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
